delay_scan_ctrl: RTL and testbench
==================================

# delay_scan_ctrl

Sequencer for the `delay_chain` tap select in the PCIe scan path. On `start` it sweeps `delay_line_rx` across every tap. At each tap it waits for the chain to settle, then counts mismatches between the resampled delayed data and a reference stream. It then finds the longest contiguous run of passing taps and programs the chain to the centre of that run, which is the eye-centre calibration for the RX skew-scan logic.

## Interface
- `NUM_TAPS`, 256: taps swept, 0..NUM_TAPS-1; must be ≤ 256.
- `SETTLE_CYC`, 16: wait cycles after each tap change; ≥ 1.
- `SAMPLE_CYC`, 1024: compare cycles per tap; ≥ 1.
- `ERR_TH`, 0: a tap passes when its error count ≤ ERR_TH.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level-sampled in IDLE only; begins a scan.
- `abort` in 1: stops a scan and restores the pre-scan tap.
- `sample_in` in 1: delayed data, already resampled into `clk`.
- `ref_in` in 1: expected data, aligned with `sample_in`.
- `delay_line_rx` out 8: tap select to `delay_chain`; registered.
- `busy` out 1: high from the cycle after `start` until the return to IDLE.
- `done` out 1: one-cycle pulse when a scan completes normally.
- `found` out 1: at least one passing tap in the last completed scan.
- `win_start` out 8: first tap of the best window.
- `win_end` out 8: last tap of the best window.
- `best_tap` out 8: centre tap that was applied.
- `pass_map` out NUM_TAPS: per-tap pass bits; present only with `DELAY_SCAN_MAP_EN`.

## Operation
- Reset: state IDLE. All outputs are 0, including `delay_line_rx`, `pass_map` and `hold_tap`.
- **IDLE**: on `start`=1, capture `hold_tap` ← `delay_line_rx`, set `delay_line_rx` ← 0, clear the window trackers, go to SETTLE. `found`, `win_*` and `best_tap` hold their last results until the next scan begins.
- **SETTLE**: count SETTLE_CYC cycles, then go to SAMPLE.
- **SAMPLE**: for SAMPLE_CYC cycles, increment the 16-bit error counter when `sample_in != ref_in`. The counter saturates at 0xFFFF. Then go to EVAL.
- **EVAL** (1 cycle):
  - pass = err ≤ ERR_TH.
  - On pass: extend the current run, or open a new run at this tap.
  - On fail, or on a pass at the last tap: close the run. Replace the best run only if its length is strictly greater, so ties keep the earlier window.
  - Clear the error counter.
  - If tap < NUM_TAPS-1: increment the tap and go to SETTLE. Otherwise go to APPLY.
- **APPLY** (1 cycle):
  - If any tap passed: `found`=1, `win_start`/`win_end` ← best run, `best_tap` = win_start + ((win_end − win_start) >> 1) (floor), `delay_line_rx` ← `best_tap`.
  - If no tap passed: `found`=0, `win_*`=0, `best_tap`=0, `delay_line_rx` ← `hold_tap`.
  - Pulse `done`, return to IDLE.
- `abort` in any non-IDLE state: next cycle `delay_line_rx` ← `hold_tap`, state IDLE, no `done` pulse, results unchanged. `abort` has priority over all in-state transitions. `abort` in IDLE has no effect.
- `start` is ignored while busy.
- Tap and window arithmetic is 9 bits wide internally, so the last tap (255) cannot wrap.

## Timing
- `start` high at edge k: at k+1 `busy`=1, `delay_line_rx`=0, state SETTLE.
- Per tap: SETTLE_CYC + SAMPLE_CYC + 1 cycles. The tap register changes on the edge that leaves EVAL.
- Full scan: NUM_TAPS·(SETTLE_CYC+SAMPLE_CYC+1) + 1 cycles from the first SETTLE cycle.
- `done`, `busy` falling, and the new `delay_line_rx`/results all take effect on the same edge (the APPLY→IDLE edge).
- `sample_in`/`ref_in` count on every SAMPLE cycle, including the first. There is no extra input pipeline.
- Reset mid-scan: synchronous return to the reset values on the next edge. `hold_tap` is not restored.

## Configuration
- `DELAY_SCAN_MAP_EN` defined:
  - adds the `pass_map` output; bit i = pass result of tap i, written in EVAL;
  - `pass_map` is cleared on scan start; abort leaves it holding the partial map.
- Not defined: no `pass_map` port or storage; all other behaviour is identical.

## Test plan
Bench parameters: SETTLE_CYC=4, SAMPLE_CYC=16, NUM_TAPS=256, ERR_TH=0 unless stated. The bench drives `sample_in` as a function of the current `delay_line_rx`.
- Taps 40..80 clean, all others 1 error each → `found`=1, `win_start`=40, `win_end`=80, `best_tap`=60, `delay_line_rx`=60. `done` arrives 256·21+1 cycles after the first SETTLE cycle.
- Clean runs 10..19 and 100..119 → window 100..119, `best_tap`=109. With clean runs 10..19 and 30..39 instead (tie) → window 10..19, `best_tap`=14.
- No clean tap, pre-scan `delay_line_rx`=0x33 (set by a prior scan) → `found`=0, `win_*`=0, `best_tap`=0, `delay_line_rx`=0x33, `done` pulses once.
- Clean taps 200..255 → `win_end`=255, `best_tap`=227, no wrap. Also check with all 256 taps clean → window 0..255, `best_tap`=127.
- Abort while `delay_line_rx`=50 → next cycle `busy`=0, `delay_line_rx`=hold value, no `done`. A `start` pulsed mid-scan has no effect.
- ERR_TH=2: 2 errors at a tap → pass; 3 errors → fail. With the macro defined, `pass_map` bits match these results.

Source files
------------

// File: rtl/delay_scan_ctrl.sv
// delay_scan_ctrl: sweeps the delay_chain tap select, counts sample/reference
// mismatches per tap, and programs the centre of the longest passing run.
// Optional build macro DELAY_SCAN_MAP_EN adds the per-tap pass_map output.
module delay_scan_ctrl #(
    parameter int unsigned NUM_TAPS   = 256,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned SAMPLE_CYC = 1024,
    parameter int unsigned ERR_TH     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                sample_in,
    input  logic                ref_in,
    output logic [7:0]          delay_line_rx,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [7:0]          win_start,
    output logic [7:0]          win_end,
    output logic [7:0]          best_tap
`ifdef DELAY_SCAN_MAP_EN
    ,
    output logic [NUM_TAPS-1:0] pass_map
`endif
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TAP_W   = 9;
    localparam int unsigned ERR_W   = 16;
    localparam int unsigned IDX_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_LIM     = ERR_W'(ERR_TH);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_APPLY
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ERR_W-1:0]   err_q;
    logic [TAP_W-1:0]   tap_q;
    logic [TAP_W-1:0]   run_start_q;
    logic [TAP_W-1:0]   run_len_q;
    logic [TAP_W-1:0]   best_start_q;
    logic [TAP_W-1:0]   best_len_q;
    logic [7:0]         hold_q;
    logic [7:0]         dl_q;
    logic               busy_q;
    logic               done_q;
    logic               found_q;
    logic [7:0]         win_start_q;
    logic [7:0]         win_end_q;
    logic [7:0]         best_tap_q;
`ifdef DELAY_SCAN_MAP_EN
    logic [NUM_TAPS-1:0] pass_map_q;
`endif

    logic               pass_c;
    logic               close_c;
    logic               take_c;
    logic [TAP_W-1:0]   run_len_d;
    logic [TAP_W-1:0]   run_start_d;
    logic [TAP_W-1:0]   cand_len_c;
    logic [TAP_W-1:0]   win_end_c;
    logic [TAP_W-1:0]   best_tap_c;

    // Run tracking for the EVAL cycle and centre computation for APPLY.
    always_comb begin
        pass_c      = (err_q <= ERR_LIM);
        run_len_d   = pass_c ? (run_len_q + TAP_W'(1)) : '0;
        run_start_d = (pass_c && (run_len_q == '0)) ? tap_q : run_start_q;
        close_c     = !pass_c || (tap_q == LAST_TAP);
        cand_len_c  = pass_c ? run_len_d : run_len_q;
        take_c      = close_c && (cand_len_c > best_len_q);
        win_end_c   = best_start_q + best_len_q - TAP_W'(1);
        best_tap_c  = best_start_q + ((best_len_q - TAP_W'(1)) >> 1);
    end

    // Scan sequencer: state, counters, window trackers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            err_q        <= '0;
            tap_q        <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            hold_q       <= '0;
            dl_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            win_start_q  <= '0;
            win_end_q    <= '0;
            best_tap_q   <= '0;
`ifdef DELAY_SCAN_MAP_EN
            pass_map_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if ((state_q != S_IDLE) && abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                dl_q    <= hold_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            hold_q       <= dl_q;
                            dl_q         <= '0;
                            tap_q        <= '0;
                            cnt_q        <= '0;
                            err_q        <= '0;
                            run_start_q  <= '0;
                            run_len_q    <= '0;
                            best_start_q <= '0;
                            best_len_q   <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= S_SETTLE;
`ifdef DELAY_SCAN_MAP_EN
                            pass_map_q   <= '0;
`endif
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_SAMPLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_SAMPLE: begin
                        if ((sample_in != ref_in) && (err_q != '1)) begin
                            err_q <= err_q + ERR_W'(1);
                        end
                        if (cnt_q == SAMPLE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_EVAL;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_EVAL: begin
                        run_len_q   <= run_len_d;
                        run_start_q <= run_start_d;
                        if (take_c) begin
                            best_len_q   <= cand_len_c;
                            best_start_q <= run_start_d;
                        end
                        err_q <= '0;
`ifdef DELAY_SCAN_MAP_EN
                        pass_map_q[tap_q[IDX_W-1:0]] <= pass_c;
`endif
                        if (tap_q != LAST_TAP) begin
                            tap_q   <= tap_q + TAP_W'(1);
                            dl_q    <= 8'(tap_q + TAP_W'(1));
                            state_q <= S_SETTLE;
                        end else begin
                            state_q <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        if (best_len_q != '0) begin
                            found_q     <= 1'b1;
                            win_start_q <= best_start_q[7:0];
                            win_end_q   <= 8'(win_end_c);
                            best_tap_q  <= 8'(best_tap_c);
                            dl_q        <= 8'(best_tap_c);
                        end else begin
                            found_q     <= 1'b0;
                            win_start_q <= '0;
                            win_end_q   <= '0;
                            best_tap_q  <= '0;
                            dl_q        <= hold_q;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign delay_line_rx = dl_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign win_start     = win_start_q;
    assign win_end       = win_end_q;
    assign best_tap      = best_tap_q;
`ifdef DELAY_SCAN_MAP_EN
    assign pass_map      = pass_map_q;
`endif

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Bench for delay_scan_ctrl: table of clean-tap patterns with expected
// windows, scoreboard of expected results, plus abort/start/ERR_TH sequences.
module tb_delay_scan_ctrl;

    localparam int SETTLE   = 4;
    localparam int SAMPLE   = 16;
    localparam int PER_TAP  = SETTLE + SAMPLE + 1;
    localparam int SCAN_CYC = 256 * PER_TAP + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, abort0, s0, r0, start2, abort2, s2, r2;
    logic [7:0] dl0, ws0, we0, bt0, dl2, ws2, we2, bt2;
    logic       busy0, done0, found0, busy2, done2, found2;
`ifdef DELAY_SCAN_MAP_EN
    logic [255:0] pm0, pm2;
`endif

    delay_scan_ctrl #(.NUM_TAPS(256), .SETTLE_CYC(SETTLE), .SAMPLE_CYC(SAMPLE), .ERR_TH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .sample_in(s0), .ref_in(r0), .delay_line_rx(dl0), .busy(busy0),
        .done(done0), .found(found0), .win_start(ws0), .win_end(we0),
        .best_tap(bt0)
`ifdef DELAY_SCAN_MAP_EN
        , .pass_map(pm0)
`endif
    );

    delay_scan_ctrl #(.NUM_TAPS(256), .SETTLE_CYC(SETTLE), .SAMPLE_CYC(SAMPLE), .ERR_TH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .sample_in(s2), .ref_in(r2), .delay_line_rx(dl2), .busy(busy2),
        .done(done2), .found(found2), .win_start(ws2), .win_end(we2),
        .best_tap(bt2)
`ifdef DELAY_SCAN_MAP_EN
        , .pass_map(pm2)
`endif
    );

    // Per-tap error counts; errors are injected in the first cycles of the sample window.
    int err0 [256];
    int err2 [256];
    int cnt0, cnt2;

    // Cycle position within the current tap (0..PER_TAP-1), restarted while idle.
    always @(posedge clk) begin
        if (!busy0 || cnt0 == PER_TAP - 1) cnt0 <= 0; else cnt0 <= cnt0 + 1;
        if (!busy2 || cnt2 == PER_TAP - 1) cnt2 <= 0; else cnt2 <= cnt2 + 1;
    end

    // Sample stream = reference, flipped on the first err[tap] sample cycles.
    always_comb begin
        r0 = cnt0[0];
        s0 = r0 ^ ((cnt0 >= SETTLE) && (cnt0 < SETTLE + err0[dl0]));
        r2 = ~cnt2[0];
        s2 = r2 ^ ((cnt2 >= SETTLE) && (cnt2 < SETTLE + err2[dl2]));
    end

    typedef struct {
        logic       fnd;
        logic [7:0] ws;
        logic [7:0] we;
        logic [7:0] bt;
        logic [7:0] dl;
    } exp_t;

    typedef struct {
        int   lo1;
        int   hi1;
        int   lo2;
        int   hi2;
        exp_t res;
    } vec_t;

    vec_t vecs [7];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t get_res(input int sel);
        exp_t r;
        if (sel != 0) begin
            r.fnd = found2; r.ws = ws2; r.we = we2; r.bt = bt2; r.dl = dl2;
        end else begin
            r.fnd = found0; r.ws = ws0; r.we = we0; r.bt = bt0; r.dl = dl0;
        end
        return r;
    endfunction

    task automatic set_pattern0(input int lo1, input int hi1, input int lo2, input int hi2);
        for (int i = 0; i < 256; i++)
            err0[i] = ((i >= lo1 && i <= hi1) || (i >= lo2 && i <= hi2)) ? 0 : 1;
    endtask

    // Start a scan on instance sel, time it, and compare against the scoreboard head.
    task automatic run_scan(input int sel, input string tag);
        int   n;
        exp_t e, a;
        if (sel != 0) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        chk({tag, "_busy_rise"}, (sel != 0) ? busy2 : busy0, 1);
        chk({tag, "_tap0"}, (sel != 0) ? dl2 : dl0, 0);
        n = 0;
        while (((sel != 0) ? done2 : done0) !== 1'b1 && n < SCAN_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_scan_cycles"}, n, SCAN_CYC);
        chk({tag, "_busy_fall"}, (sel != 0) ? busy2 : busy0, 0);
        a = get_res(sel);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_found"}, a.fnd, e.fnd);
            chk({tag, "_win_start"}, a.ws, e.ws);
            chk({tag, "_win_end"}, a.we, e.we);
            chk({tag, "_best_tap"}, a.bt, e.bt);
            chk({tag, "_delay_line"}, a.dl, e.dl);
        end
        @(negedge clk);
        chk({tag, "_done_single"}, (sel != 0) ? done2 : done0, 0);
    endtask

    initial begin
        int   n;
        int   dones;
        exp_t e;

        vecs[0] = '{lo1: 40,  hi1: 80,  lo2: -1, hi2: -1, res: '{1'b1, 8'd40,  8'd80,  8'd60,  8'd60}};
        vecs[1] = '{lo1: 10,  hi1: 19,  lo2: 100, hi2: 119, res: '{1'b1, 8'd100, 8'd119, 8'd109, 8'd109}};
        vecs[2] = '{lo1: 10,  hi1: 19,  lo2: 30, hi2: 39, res: '{1'b1, 8'd10,  8'd19,  8'd14,  8'd14}};
        vecs[3] = '{lo1: 51,  hi1: 51,  lo2: -1, hi2: -1, res: '{1'b1, 8'd51,  8'd51,  8'd51,  8'h33}};
        vecs[4] = '{lo1: -1,  hi1: -1,  lo2: -1, hi2: -1, res: '{1'b0, 8'd0,   8'd0,   8'd0,   8'h33}};
        vecs[5] = '{lo1: 200, hi1: 255, lo2: -1, hi2: -1, res: '{1'b1, 8'd200, 8'd255, 8'd227, 8'd227}};
        vecs[6] = '{lo1: 0,   hi1: 255, lo2: -1, hi2: -1, res: '{1'b1, 8'd0,   8'd255, 8'd127, 8'd127}};

        for (int i = 0; i < 256; i++) begin
            err0[i] = 1;
            err2[i] = (i >= 100 && i <= 109) ? 2 : ((i >= 110 && i <= 119) ? 0 : 3);
        end

        rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {dl0, ws0, we0, bt0, busy0, done0, found0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a scan returns to reset values.
        set_pattern0(40, 80, -1, -1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (30) @(negedge clk);
        chk("midscan_tap1", dl0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midscan_reset", {dl0, busy0, done0, found0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            set_pattern0(vecs[i].lo1, vecs[i].hi1, vecs[i].lo2, vecs[i].hi2);
            sb_q.push_back(vecs[i].res);
            run_scan(0, $sformatf("vec%0d", i));
        end

        // Abort mid-scan, with an ignored start pulse beforehand.
        set_pattern0(40, 80, -1, -1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (dl0 != 8'd45 && n < 2000) begin @(negedge clk); n++; end
        chk("reach_tap45", (n < 2000), 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("start_ignored", {busy0, dl0}, {1'b1, 8'd45});
        n = 0;
        while (dl0 != 8'd50 && n < 2000) begin @(negedge clk); n++; end
        chk("reach_tap50", (n < 2000), 1);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_restore", dl0, 8'd127);
        chk("abort_results", {found0, ws0, we0, bt0}, {1'b1, 8'd0, 8'd255, 8'd127});
`ifdef DELAY_SCAN_MAP_EN
        chk("abort_partial_map", {pm0[39], pm0[45], pm0[100]}, 3'b010);
`endif
        dones = (done0 === 1'b1) ? 1 : 0;
        repeat (40) begin
            @(negedge clk);
            if (done0 === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("idle_abort_noeffect", {busy0, dl0}, {1'b0, 8'd127});

        // ERR_TH=2: taps with 2 errors pass, 3 errors fail.
        e = '{1'b1, 8'd100, 8'd119, 8'd109, 8'd109};
        sb_q.push_back(e);
        run_scan(2, "errth2");
`ifdef DELAY_SCAN_MAP_EN
        chk("errth2_map", {pm2[99], pm2[100], pm2[119], pm2[120]}, 4'b0110);
`endif
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
